// File: rtl/fetch_unit.sv
// Instruction fetch: PC, IR and LUT-based jump/branch redirect with halt detection. IR is valid 1 cycle after PC; a redirect costs 1 bubble.
// Backpressure: stall freezes PC/IR/state; a pending redirect stays visible in IR and is taken once stall drops.
module fetch_unit #(
  parameter int                     PC_W       = 10,
  parameter int                     INST_W     = 9,
  parameter int                     LUT_D      = 5,
  parameter logic [PC_W-1:0]        START_ADDR = '0,
  parameter logic [INST_W-1:0]      HALT_OP    = 9'h1FF
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                start,
  input  logic                stall,
  input  logic                jump_en,
  input  logic                branch_en,
  input  logic [LUT_D-1:0]    target_idx,
  input  logic [INST_W-1:0]   inst_in,
  input  logic                lut_we,
  input  logic [LUT_D-1:0]    lut_waddr,
  input  logic [PC_W-1:0]     lut_wdata,
  output logic [PC_W-1:0]     PC,
  output logic [INST_W-1:0]   Instruction,
  output logic [PC_W-1:0]     inst_pc,
  output logic                inst_valid,
  output logic                halt,
  output logic [15:0]         fetch_ct
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FLUSH  = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  logic [1:0]      state;
  logic [PC_W-1:0] lut [2**LUT_D];
  logic [PC_W-1:0] lut_rd;
  logic [PC_W-1:0] redirect_pc;
  logic            redirect;
  logic            halt_hit;

  // Read-before-write: a same-cycle write to target_idx is seen only next cycle.
  always_ff @(posedge CLK) begin
    if (lut_we) lut[lut_waddr] <= lut_wdata;
  end

  assign lut_rd = lut[target_idx];

  always_comb begin
    redirect    = (state == S_RUN) && inst_valid && (jump_en || branch_en);
    halt_hit    = (state == S_RUN) && inst_valid && (Instruction == HALT_OP);
    // LUT entry is already PC_W wide, so modulo addition is the sign-extended offset.
    redirect_pc = jump_en ? lut_rd : (inst_pc + lut_rd);
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      PC          <= START_ADDR;
      Instruction <= '0;
      inst_pc     <= '0;
      inst_valid  <= 1'b0;
      halt        <= 1'b0;
      fetch_ct    <= '0;
    end else if (start) begin
      state       <= S_RUN;
      PC          <= START_ADDR;
      Instruction <= '0;
      inst_pc     <= '0;
      inst_valid  <= 1'b0;
      halt        <= 1'b0;
      fetch_ct    <= '0;
    end else if (halt_hit) begin
      halt  <= 1'b1;
      state <= S_HALTED;
    end else if (!stall) begin
      case (state)
        S_RUN, S_FLUSH: begin
          if (redirect) begin
            PC          <= redirect_pc;
            Instruction <= '0;
            inst_valid  <= 1'b0;
            state       <= S_FLUSH;
          end else begin
            Instruction <= inst_in;
            inst_pc     <= PC;
            inst_valid  <= 1'b1;
            PC          <= PC + PC_W'(1);
            state       <= S_RUN;
            if (fetch_ct != 16'hFFFF) fetch_ct <= fetch_ct + 16'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, wrap, jump/branch, stall, halt and async reset.
module tb_fetch_unit;

  logic       CLK;
  logic       reset;
  logic       start;
  logic       stall;
  logic       jump_en;
  logic       branch_en;
  logic [4:0] target_idx;
  logic [8:0] inst_in;
  logic       lut_we;
  logic [4:0] lut_waddr;
  logic [9:0] lut_wdata;
  logic [9:0] PC;
  logic [8:0] Instruction;
  logic [9:0] inst_pc;
  logic       inst_valid;
  logic       halt;
  logic [15:0] fetch_ct;

  logic [8:0] rom [1024];
  int n_checks;
  int n_errors;

  fetch_unit dut (
    .CLK(CLK), .reset(reset), .start(start), .stall(stall),
    .jump_en(jump_en), .branch_en(branch_en), .target_idx(target_idx),
    .inst_in(inst_in), .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .PC(PC), .Instruction(Instruction), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .halt(halt), .fetch_ct(fetch_ct)
  );

  assign inst_in = rom[PC];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int k = 0; k < 1024; k++) rom[k] = 9'(k);
    rom[511]  = 9'h0AA;
    rom[1023] = 9'h0AA;

    reset = 1'b0; start = 1'b0; stall = 1'b0; jump_en = 1'b0; branch_en = 1'b0;
    target_idx = '0; lut_we = 1'b0; lut_waddr = '0; lut_wdata = '0;
    #2;
    check_val("rst_pc", PC, 0);
    check_val("rst_ir", Instruction, 0);
    check_val("rst_ipc", inst_pc, 0);
    check_val("rst_vld", inst_valid, 0);
    check_val("rst_halt", halt, 0);
    check_val("rst_ct", fetch_ct, 0);

    step();
    reset = 1'b1;
    // Program LUT while idle.
    lut_we = 1'b1; lut_waddr = 5'd3; lut_wdata = 10'd200;
    step();
    lut_waddr = 5'd1; lut_wdata = 10'h3FC;
    step();
    lut_waddr = 5'd2; lut_wdata = 10'd50;
    step();
    lut_we = 1'b0;
    check_val("idle_pc", PC, 0);
    check_val("idle_vld", inst_valid, 0);

    start = 1'b1;
    step();
    start = 1'b0;
    check_val("start_pc", PC, 0);
    check_val("start_vld", inst_valid, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      check_val("seq_ir", Instruction, k);
      check_val("seq_ipc", inst_pc, k);
      check_val("seq_vld", inst_valid, 1);
    end
    check_val("seq_ct", fetch_ct, 4);
    check_val("seq_pc", PC, 4);

    step();
    step();
    check_val("pre_jmp_ipc", inst_pc, 5);
    jump_en = 1'b1; target_idx = 5'd3;
    step();
    jump_en = 1'b0;
    check_val("jmp_pc", PC, 200);
    check_val("jmp_vld", inst_valid, 0);
    check_val("jmp_ir", Instruction, 0);
    step();
    check_val("jmp_ir2", Instruction, 200);
    check_val("jmp_ipc2", inst_pc, 200);
    check_val("jmp_vld2", inst_valid, 1);
    check_val("jmp_ct", fetch_ct, 7);

    jump_en = 1'b1; target_idx = 5'd2;
    step();
    jump_en = 1'b0;
    check_val("jmp50_pc", PC, 50);
    step();
    check_val("jmp50_ipc", inst_pc, 50);
    branch_en = 1'b1; target_idx = 5'd1;
    step();
    branch_en = 1'b0;
    check_val("br_pc", PC, 46);
    check_val("br_vld", inst_valid, 0);
    step();
    check_val("br_ir", Instruction, 46);
    check_val("br_ipc", inst_pc, 46);
    jump_en = 1'b1; branch_en = 1'b1; target_idx = 5'd1;
    step();
    jump_en = 1'b0; branch_en = 1'b0;
    check_val("both_pc", PC, 10'h3FC);

    step();
    step();
    check_val("wrap_pc0", PC, 1022);
    step();
    check_val("wrap_pc1", PC, 1023);
    check_val("wrap_vld1", inst_valid, 1);
    step();
    check_val("wrap_pc2", PC, 0);
    check_val("wrap_ipc2", inst_pc, 1023);
    check_val("wrap_vld2", inst_valid, 1);
    step();
    check_val("wrap_pc3", PC, 1);
    check_val("wrap_ipc3", inst_pc, 0);
    check_val("wrap_vld3", inst_valid, 1);

    // Jump held under stall; LUT rewrite on the release edge must not affect it.
    stall = 1'b1; jump_en = 1'b1; target_idx = 5'd3;
    for (int k = 0; k < 3; k++) begin
      step();
      check_val("stall_pc", PC, 1);
      check_val("stall_ipc", inst_pc, 0);
      check_val("stall_vld", inst_valid, 1);
    end
    stall = 1'b0; lut_we = 1'b1; lut_waddr = 5'd3; lut_wdata = 10'd300;
    step();
    jump_en = 1'b0; lut_we = 1'b0;
    check_val("unstall_pc", PC, 200);
    check_val("unstall_vld", inst_valid, 0);
    step();
    check_val("unstall_ir", Instruction, 200);
    jump_en = 1'b1; target_idx = 5'd3;
    step();
    jump_en = 1'b0;
    check_val("lut_new_pc", PC, 300);
    step();

    rom[7] = 9'h1FF;
    start = 1'b1;
    step();
    start = 1'b0;
    check_val("rs_ct", fetch_ct, 0);
    for (int k = 0; k < 8; k++) step();
    check_val("hlt_ir", Instruction, 9'h1FF);
    check_val("hlt_pre", halt, 0);
    check_val("hlt_ct0", fetch_ct, 8);
    step();
    check_val("hlt_set", halt, 1);
    check_val("hlt_pc", PC, 8);
    for (int k = 0; k < 20; k++) begin
      stall = k[0];
      step();
      check_val("frz_pc", PC, 8);
    end
    stall = 1'b0;
    check_val("frz_ir", Instruction, 9'h1FF);
    check_val("frz_ct", fetch_ct, 8);
    check_val("frz_halt", halt, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    check_val("restart_halt", halt, 0);
    check_val("restart_pc", PC, 0);

    step();
    step();
    step();
    check_val("mid_pc", PC, 3);
    #2;
    reset = 1'b0;
    #1;
    check_val("arst_pc", PC, 0);
    check_val("arst_ir", Instruction, 0);
    check_val("arst_ipc", inst_pc, 0);
    check_val("arst_vld", inst_valid, 0);
    check_val("arst_halt", halt, 0);
    check_val("arst_ct", fetch_ct, 0);
    reset = 1'b1;
    step();
    step();
    check_val("post_rst_pc", PC, 0);
    check_val("post_rst_vld", inst_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
